// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM state encoding,
// divider floor and 8N1 frame shape.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int DIV_W     = 16;
    localparam int DIV_MIN   = 4;
    localparam int DATA_BITS = 8;

    // Below DIV_MIN the half-period load would underflow or leave no margin.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through synchronous FIFO. Head entry is presented
// combinationally; head reads as zero while empty.
module rx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; no reset needed since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with sticky framing and
// overrun flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = 106,
    parameter int FIFO_DEPTH  = 8,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_rx,
    input  logic             cfg_div_we,
    input  logic [15:0]      cfg_div_di,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    fifo_count,
    output logic             err_frame,
    output logic             err_overrun,
    input  logic             err_clr
);

    logic             sync1;
    logic             rx_s;
    logic [1:0]       sync_ok;
    logic             rx_prev;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] frame_div;
    logic [DIV_W-1:0] cnt;
    rx_state_e        state;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick;
    logic             start_edge;
    logic             push;
    logic             frame_evt;
    logic             ovr_evt;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    // Two-flop synchronizer; idle-high reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= ser_rx;
            rx_s  <= sync1;
        end
    end

    // rx_prev only goes high once a real sampled high has passed through the
    // synchronizer, so a line held low across reset release never looks like
    // a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ok <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            sync_ok <= {sync_ok[0], 1'b1};
            rx_prev <= sync_ok[1] & rx_s;
        end
    end

    // Divider register; sampled into frame_div only at a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_reg <= DIV_W'(DEFAULT_DIV);
        else if (cfg_div_we)
            div_reg <= cfg_div_di;
    end

    assign tick       = (state != IDLE) && (cnt == '0);
    assign start_edge = (state == IDLE) && rx_prev && !rx_s;
    assign push       = (state == STOP) && tick && rx_s;
    assign frame_evt  = (state == STOP) && tick && !rx_s;

    // Receive FSM with bit counter, bit index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_div <= DIV_W'(DEFAULT_DIV);
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        frame_div <= clamp_div(div_reg);
                        cnt       <= (clamp_div(div_reg) >> 1) - 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                            cnt     <= frame_div - 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= frame_div - 1'b1;
                        if (bit_idx == 3'(DATA_BITS - 1))
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (tick)
                        state <= rx_s ? IDLE : WAIT_IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                WAIT_IDLE: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign ovr_evt   = push && fifo_full && !pop;

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= frame_evt | (err_frame & ~err_clr);
            err_overrun <= ovr_evt | (err_overrun & ~err_clr);
        end
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ser_rx = 1'b1;
    logic        cfg_div_we = 1'b0;
    logic [15:0] cfg_div_di = 16'd0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fifo_count;
    logic        err_frame;
    logic        err_overrun;
    logic        err_clr = 1'b0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int cur_div = 106;
    bit cmp_en = 0;
    bit rand_ready = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         mf = 0;
    bit         mo = 0;
    int         ev_cyc[$];
    logic [7:0] ev_b[$];
    bit         ev_ok[$];
    logic [7:0] got[$];

    uart_rx_fifo #(.DEFAULT_DIV(106), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .ser_rx      (ser_rx),
        .cfg_div_we  (cfg_div_we),
        .cfg_div_di  (cfg_div_di),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passes++;
        end
    endtask

    // Model: each frame's stop sample lands at start_pin_cycle + 2 + div/2 + 9*div.
    initial begin
        bit pop_m, pushv, setf, seto;
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete(); ev_cyc.delete(); ev_b.delete(); ev_ok.delete();
                mf = 0; mo = 0;
            end else begin
                pop_m = (mq.size() > 0) && out_ready;
                pushv = 0; setf = 0; seto = 0;
                if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
                    if (!ev_ok[0]) setf = 1;
                    else if (mq.size() == DEPTH && !pop_m) seto = 1;
                    else pushv = 1;
                    if (pushv) begin
                        if (pop_m) void'(mq.pop_front());
                        mq.push_back(ev_b[0]);
                        pop_m = 0;
                    end
                    void'(ev_cyc.pop_front()); void'(ev_b.pop_front()); void'(ev_ok.pop_front());
                end
                if (pop_m) void'(mq.pop_front());
                mf = setf | (mf & ~err_clr);
                mo = seto | (mo & ~err_clr);
            end
            cyc++;
        end
    end

    // Per-cycle comparison and delivery log, sampled on the falling edge.
    initial begin
        logic [14:0] exp_v;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) got.push_back(out_data);
            if (cmp_en && !reset) begin
                exp_v = {mq.size() > 0, (mq.size() > 0) ? mq[0] : 8'h00,
                         4'(mq.size()), mf, mo};
                check("cycle {valid,data,count,ferr,ovr}",
                      {17'd0, out_valid, out_data, fifo_count, err_frame, err_overrun},
                      {17'd0, exp_v});
            end
        end
    end

    // Random consumer back-pressure when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick_n(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_div(input int v);
        cfg_div_di = 16'(v); cfg_div_we = 1'b1;
        tick_n(1);
        cfg_div_we = 1'b0;
        cur_div = (v < 4) ? 4 : v;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; tick_n(1); err_clr = 1'b0;
    endtask

    // Drives one frame at the divider in effect at its start edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low, input bit sched);
        int d;
        d = cur_div;
        if (sched) begin
            ev_cyc.push_back(cyc + 2 + d / 2 + 9 * d);
            ev_b.push_back(b);
            ev_ok.push_back(stop_ok);
        end
        ser_rx = 1'b0; tick_n(d);
        for (int i = 0; i < 8; i++) begin ser_rx = b[i]; tick_n(d); end
        ser_rx = stop_ok;
        tick_n(stop_ok ? d : d + extra_low);
        ser_rx = 1'b1;
    endtask

    task automatic check_got(input string name, input logic [7:0] exp[$]);
        check({name, " count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(name, 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [7:0] e[$];
        // Reset state
        tick_n(4);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset fifo_count", 32'(fifo_count), 32'd0);
        check("reset flags", 32'({err_frame, err_overrun}), 32'd0);
        reset = 1'b0;
        cmp_en = 1;
        tick_n(20);

        // Four clean bytes at default divider
        out_ready = 1'b1; got.delete();
        send_frame(8'h55, 1, 0, 1); tick_n(3);
        send_frame(8'hA3, 1, 0, 1); tick_n(3);
        send_frame(8'h00, 1, 0, 1); tick_n(3);
        send_frame(8'hFF, 1, 0, 1); tick_n(20);
        e = '{8'h55, 8'hA3, 8'h00, 8'hFF};
        check_got("basic bytes", e);
        check("basic flags", 32'({err_frame, err_overrun}), 32'd0);

        // Framing error, break, recovery
        got.delete();
        send_frame(8'h41, 0, 2000, 1); tick_n(20);
        check("break err_frame", 32'(err_frame), 32'd1);
        send_frame(8'h42, 1, 0, 1); tick_n(20);
        e = '{8'h42};
        check_got("after break", e);
        check("err_frame sticky", 32'(err_frame), 32'd1);
        pulse_clr();
        check("err_frame cleared", 32'(err_frame), 32'd0);

        // Overrun
        out_ready = 1'b0; got.delete();
        for (int i = 1; i <= 9; i++) begin send_frame(8'(i), 1, 0, 1); tick_n(3); end
        tick_n(10);
        check("overrun count", 32'(fifo_count), 32'd8);
        check("overrun flag", 32'(err_overrun), 32'd1);
        out_ready = 1'b1; tick_n(12);
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        check_got("overrun drain", e);
        pulse_clr();

        // Short low glitch
        ser_rx = 1'b0; tick_n(20); ser_rx = 1'b1; tick_n(200);
        check("glitch state", 32'({fifo_count, err_frame, err_overrun}), 32'd0);

        // Divider change during a frame
        got.delete();
        fork
            send_frame(8'h3C, 1, 0, 1);
            begin tick_n(300); set_div(16); end
        join
        tick_n(10);
        send_frame(8'hC3, 1, 0, 1); tick_n(20);
        e = '{8'h3C, 8'hC3};
        check_got("div change", e);

        // Reset mid-frame with bytes queued
        out_ready = 1'b0;
        send_frame(8'h11, 1, 0, 1); tick_n(3);
        send_frame(8'h22, 1, 0, 1); tick_n(3);
        send_frame(8'h33, 1, 0, 1); tick_n(10);
        check("queued before reset", 32'(fifo_count), 32'd3);
        ser_rx = 1'b0; tick_n(cur_div * 5 + cur_div / 2);
        reset = 1'b1; tick_n(1);
        check("reset fifo_count", 32'(fifo_count), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        tick_n(2); reset = 1'b0; cur_div = 106;
        tick_n(1500);
        check("held low no frame", 32'({fifo_count, err_frame}), 32'd0);
        ser_rx = 1'b1; tick_n(50);
        out_ready = 1'b1; got.delete();
        send_frame(8'h7E, 1, 0, 1); tick_n(20);
        e = '{8'h7E};
        check_got("after reset", e);

        // Randomised frames, dividers, stop errors, clears and back-pressure
        rand_ready = 1;
        for (int n = 0; n < 30; n++) begin
            set_div(int'($urandom_range(2, 40)));
            if ($urandom_range(0, 3) == 0) pulse_clr();
            send_frame(8'($urandom), $urandom_range(0, 5) != 0, int'($urandom_range(0, 60)), 1);
            tick_n(int'($urandom_range(3, 12)));
        end
        rand_ready = 0; out_ready = 1'b1;
        tick_n(30);
        check("final drain", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
